multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the 4-bit-opcode processor datapath. It replaces single-cycle decode with a FETCH/DECODE/EXEC/MEM/WB state machine.
- Drives PC, IR, register-file, ALU-source and memory controls.
- Memory accesses use a req/ack handshake with variable wait states.
- Keeps a retired-instruction counter and a halted flag.

Parameters:
CNT_W, 16, width of retired-instruction counter
HALT_OP, 4'b1110, opcode that halts the sequencer

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  synchronous active-high reset
opcode  in  4  IR[15:12]; only sampled in DECODE/EXEC/MEM/WB
zero  in  1  ALU zero flag from register compare (sampled in EXEC)
mem_ack  in  1  memory completes current access this cycle
mem_req  out  1  memory access request, held until mem_ack
mem_we  out  1  1=write (store), 0=read; valid while mem_req
addr_sel  out  1  0=PC address (fetch), 1=ALU result (data)
ir_write  out  1  load IR from memory read data
pc_write  out  1  update PC this cycle
pc_src  out  1  0=PC+1, 1=branch target
reg_write  out  1  register file write enable
reg_dst  out  1  1=rd field, 0=rt field
alu_src  out  1  1=immediate, 0=register
wb_sel  out  1  1=memory data, 0=ALU result
retire  out  1  one-cycle pulse on last cycle of each instruction
instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W
halted  out  1  high in HALT state
state  out  3  current state encoding, for debug

Behaviour:
- Opcode classes (bit0 = LSB):
  - LOAD 0000, STORE 0010, STRI 0100, BOZ 0110, BRAN 1000, COMP 1010
  - ALU = any opcode with bit0=1
  - NOP 1100, HALT = HALT_OP
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Only the state register, instr_count and halted are registered.
- Output timing: all other outputs are combinational from state and opcode. pc_write, ir_write and retire may also depend on mem_ack or zero.
- Reset: rst=1 at an edge forces FETCH, instr_count=0, halted=0, regardless of current state. Any in-flight memory access is abandoned.
- Default value: every control output is 0 unless stated below, including during the cycle after reset.
- FETCH:
  - mem_req=1, mem_we=0, addr_sel=0.
  - No mem_ack: stay.
  - mem_ack: ir_write=1, pc_write=1, pc_src=0; next DECODE.
- DECODE:
  - HALT → HALT.
  - NOP: retire=1; next FETCH.
  - Otherwise → EXEC.
- EXEC:
  - alu_src=1 for LOAD/STORE/STRI.
  - BRAN: pc_write=1, pc_src=1, retire=1; next FETCH.
  - BOZ: pc_write=zero, pc_src=1, retire=1; next FETCH.
  - LOAD/STORE → MEM.
  - STRI/COMP/ALU → WB.
- MEM:
  - addr_sel=1, alu_src=1, mem_req=1, mem_we=1 for STORE only.
  - No mem_ack: stay; outputs held stable.
  - On ack: STORE gets retire=1 and goes to FETCH; LOAD goes to WB.
- WB:
  - reg_write=1, retire=1; next FETCH.
  - wb_sel=1 for LOAD.
  - reg_dst=1 for COMP/ALU, 0 for LOAD/STRI.
  - alu_src=1 for STRI.
- HALT: halted=1; all control outputs 0; mem_ack ignored; stays until rst.
- Stray mem_ack: mem_ack outside FETCH/MEM is ignored.
- instr_count: increments by 1 on every cycle retire=1; wraps from all-ones to 0. HALT does not count as retired.
- Illegal/unused state codes (6,7) go to FETCH on the next edge.
- Zero-wait latency:
  - NOP 2 cycles
  - BRAN/BOZ 3 cycles
  - STORE, STRI/COMP/ALU 4 cycles
  - LOAD 5 cycles
  - Each memory wait cycle adds 1.

Decomposition:
- Shared package (multicycle_pkg):
  - state encodings
  - opcode constants LOAD/STORE/STRI/BOZ/BRAN/COMP/NOP/HALT
  - opcode-class decode function, returning is_load, is_store, is_stri, is_boz, is_bran, is_comp, is_alu, is_nop, is_halt
- Sub-module: one natural sub-module, op_class_decode, a combinational opcode→class decoder that replaces the single-cycle decode equations.
- Top level: the FSM and counter stay in the top.

Test Plan:
- Reset mid-MEM, STORE with mem_ack low: assert rst for 1 cycle → next state FETCH, mem_req=1 fetch with mem_we=0, instr_count=0.
- ALU op 0001, mem_ack always 1: state sequence 0,1,2,4,0. reg_write=1 and reg_dst=1 only in WB; retire once; count 0→1.
- LOAD 0000 with mem_ack delayed 3 cycles in MEM:
  - MEM held 4 cycles with mem_req=1, mem_we=0, addr_sel=1 stable.
  - Then WB with wb_sel=1, reg_dst=0.
  - Total 8 cycles.
- BOZ 0110:
  - zero=1 → pc_write=1, pc_src=1 in EXEC.
  - zero=0 → pc_write=0.
  - Both cases retire and return to FETCH in 3 cycles.
- HALT 1110 after 5 NOPs:
  - instr_count=5, halted=1.
  - No mem_req for 20 cycles even with mem_ack toggling.
  - rst clears to FETCH.
- Counter wrap with CNT_W=4: 17 NOPs → instr_count=1 (15→0 wrap observed at the 16th retire).

Source files
------------

// File: rtl/multicycle_pkg.sv
// multicycle_pkg: state encodings, opcode constants and opcode-class decode shared by the sequencer
package multicycle_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [3:0] OP_LOAD  = 4'b0000;
   localparam logic [3:0] OP_STORE = 4'b0010;
   localparam logic [3:0] OP_STRI  = 4'b0100;
   localparam logic [3:0] OP_BOZ   = 4'b0110;
   localparam logic [3:0] OP_BRAN  = 4'b1000;
   localparam logic [3:0] OP_COMP  = 4'b1010;
   localparam logic [3:0] OP_NOP   = 4'b1100;
   localparam logic [3:0] OP_HALT  = 4'b1110;

   typedef struct packed {
      logic is_load;
      logic is_store;
      logic is_stri;
      logic is_boz;
      logic is_bran;
      logic is_comp;
      logic is_alu;
      logic is_nop;
      logic is_halt;
   } op_class_t;

   // halt wins over every other class so a reconfigured HALT_OP never aliases two classes
   function automatic op_class_t classify(input logic [3:0] op, input logic [3:0] halt_op);
      op_class_t c;
      c.is_halt  = (op == halt_op);
      c.is_alu   = op[0] & ~c.is_halt;
      c.is_load  = (op == OP_LOAD) & ~c.is_halt;
      c.is_store = (op == OP_STORE) & ~c.is_halt;
      c.is_stri  = (op == OP_STRI) & ~c.is_halt;
      c.is_boz   = (op == OP_BOZ) & ~c.is_halt;
      c.is_bran  = (op == OP_BRAN) & ~c.is_halt;
      c.is_comp  = (op == OP_COMP) & ~c.is_halt;
      c.is_nop   = (op == OP_NOP) & ~c.is_halt;
      return c;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_op_class_decode.sv
// op_class_decode: combinational opcode to instruction-class decoder
module op_class_decode
   import multicycle_pkg::*;
#(
   parameter logic [3:0] HALT_OP = OP_HALT
) (
   input  logic [3:0] opcode,
   output op_class_t  cls
);

   assign cls = classify(opcode, HALT_OP);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer with retired-instruction counter and halt
module multicycle_ctrl
   import multicycle_pkg::*;
#(
   parameter int         CNT_W   = 16,
   parameter logic [3:0] HALT_OP = 4'b1110
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       opcode,
   input  logic             zero,
   input  logic             mem_ack,
   output logic             mem_req,
   output logic             mem_we,
   output logic             addr_sel,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_src,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             alu_src,
   output logic             wb_sel,
   output logic             retire,
   output logic [CNT_W-1:0] instr_count,
   output logic             halted,
   output logic [2:0]       state
);

   state_t    st, nxt;
   op_class_t cls;

   op_class_decode #(.HALT_OP(HALT_OP)) u_dec (
      .opcode(opcode),
      .cls   (cls)
   );

   assign state = st;

   // next state and combinational control outputs; mem_ack only matters in FETCH and MEM
   always_comb begin
      nxt       = st;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 1'b0;
      reg_write = 1'b0;
      reg_dst   = 1'b0;
      alu_src   = 1'b0;
      wb_sel    = 1'b0;
      retire    = 1'b0;
      case (st)
         S_FETCH: begin
            mem_req  = 1'b1;
            ir_write = mem_ack;
            pc_write = mem_ack;
            nxt      = mem_ack ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            retire = cls.is_nop;
            nxt    = cls.is_halt ? S_HALT : cls.is_nop ? S_FETCH : S_EXEC;
         end
         S_EXEC: begin
            alu_src  = cls.is_load | cls.is_store | cls.is_stri;
            pc_write = cls.is_bran | (cls.is_boz & zero);
            pc_src   = cls.is_bran | cls.is_boz;
            retire   = cls.is_bran | cls.is_boz;
            nxt      = (cls.is_bran | cls.is_boz) ? S_FETCH :
                       (cls.is_load | cls.is_store) ? S_MEM : S_WB;
         end
         S_MEM: begin
            mem_req  = 1'b1;
            mem_we   = cls.is_store;
            addr_sel = 1'b1;
            alu_src  = 1'b1;
            retire   = mem_ack & cls.is_store;
            nxt      = !mem_ack ? S_MEM : cls.is_store ? S_FETCH : S_WB;
         end
         S_WB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            wb_sel    = cls.is_load;
            reg_dst   = cls.is_comp | cls.is_alu;
            alu_src   = cls.is_stri;
            nxt       = S_FETCH;
         end
         S_HALT: nxt = S_HALT;
         default: nxt = S_FETCH;
      endcase
   end

   // state, retired-instruction counter and halted flag
   always_ff @(posedge clk) begin
      if (rst) begin
         st          <= S_FETCH;
         instr_count <= '0;
         halted      <= 1'b0;
      end else begin
         st     <= nxt;
         halted <= (nxt == S_HALT);
         if (retire) instr_count <= instr_count + CNT_W'(1);
      end
   end

endmodule
